muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit. It consumes the two operands read from the register file (rs1_data, rs2_data) together with the destination index, and computes one of the eight M-extension operations over multiple cycles. It then presents the 32-bit result as a single-cycle write-back (rd, rdv, w_en) that feeds the register file write port directly. There is one operation in flight at a time, and it can be aborted by a pipeline flush.

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_if.sv | 32 +++
 rtl/muldiv_unit.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types and constants for the iterative RV32M multiply/divide unit:
//   funct3_e : RV32M operation encoding (funct3 field)
//   state_e  : control FSM states
//   XLEN, STEPS, INT_MIN, ALL_ONES : datapath width and corner-case constants
// -----------------------------------------------------------------------------
package muldiv_pkg;

  localparam int          XLEN     = 32;
  localparam int          STEPS    = 32;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
// Request / write-back bundle between the issue stage and the mul/div unit.
//   Request  (master -> slave): start, funct3, op_a, op_b, rd_in, flush
//   Response (slave -> master): ready, done, rd, rdv, w_en
// -----------------------------------------------------------------------------
interface muldiv_if;
  import muldiv_pkg::*;

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            flush;
  logic            ready;
  logic            done;
  logic [4:0]      rd;
  logic [XLEN-1:0] rdv;
  logic            w_en;

  modport master (
    output start, funct3, op_a, op_b, rd_in, flush,
    input  ready, done, rd, rdv, w_en
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in, flush,
    output ready, done, rd, rdv, w_en
  );

endinterface

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit, one operation in flight.
//   clk   : clock, rising-edge
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_if.slave
//           start/funct3/op_a/op_b/rd_in : request, accepted while ready=1
//           flush : abort the operation in CALC (drops a start in IDLE)
//           ready : unit idle
//           done/rd/rdv/w_en : registered one-cycle write-back
// Operand magnitudes are processed unsigned in a shared 64-bit shift register
// with one 33-bit adder/subtractor; signs are re-applied on the last step.
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);
  import muldiv_pkg::*;

  localparam int W2 = 2 * XLEN;

  function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic en);
    return en ? (~v + XLEN'(1)) : v;
  endfunction

  function automatic logic [W2-1:0] cneg2(input logic [W2-1:0] v, input logic en);
    return en ? (~v + W2'(1)) : v;
  endfunction

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
    return cneg(v, is_signed & v[XLEN-1]);
  endfunction

  // control state
  state_e          r_state;
  logic [4:0]      r_cnt;
  logic            r_done;
  logic            r_wen;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_rdv;

  // operation context and datapath
  funct3_e         r_f3;
  logic            r_sign_a;
  logic            r_sign_b;
  logic [4:0]      r_rd_lat;
  logic [XLEN-1:0] r_opnd;
  logic [W2-1:0]   r_acc;

  // request decode
  funct3_e         w_f3;
  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_div0;
  logic            w_ovf;
  logic            w_special;
  logic            w_accept;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic [XLEN-1:0] w_special_res;

  always_comb begin
    w_f3       = funct3_e'(bus.funct3);
    w_is_div   = bus.funct3[2];
    w_a_signed = (w_f3 == F3_MUL) || (w_f3 == F3_MULH) || (w_f3 == F3_MULHSU) ||
                 (w_f3 == F3_DIV) || (w_f3 == F3_REM);
    w_b_signed = (w_f3 == F3_MUL) || (w_f3 == F3_MULH) ||
                 (w_f3 == F3_DIV) || (w_f3 == F3_REM);
    w_mag_a    = mag(bus.op_a, w_a_signed);
    w_mag_b    = mag(bus.op_b, w_b_signed);
    w_div0     = w_is_div && (bus.op_b == '0);
    w_ovf      = ((w_f3 == F3_DIV) || (w_f3 == F3_REM)) &&
                 (bus.op_a == INT_MIN) && (bus.op_b == ALL_ONES);
    w_special  = w_div0 || w_ovf;
    // funct3[1] separates REM/REMU from DIV/DIVU
    w_special_res = ALL_ONES;
    if (w_div0)     w_special_res = bus.funct3[1] ? bus.op_a : ALL_ONES;
    else if (w_ovf) w_special_res = bus.funct3[1] ? '0 : INT_MIN;
    w_accept   = (r_state == S_IDLE) && bus.start && !bus.flush;
  end

  // one iteration step plus sign fix-up of the step's outcome
  logic            w_div;
  logic [XLEN-1:0] w_alu_x;
  logic [XLEN:0]   w_alu;
  logic            w_ge;
  logic [W2-1:0]   w_acc_nxt;
  logic [W2-1:0]   w_prod;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_result;

  always_comb begin
    w_div   = r_f3[2];
    // divide works on the partial remainder after the left shift
    w_alu_x = w_div ? r_acc[W2-2:XLEN-1] : r_acc[W2-1:XLEN];
    // add for multiply, subtract (invert + carry-in) for divide;
    // for subtract, w_alu[XLEN] is the borrow
    w_alu   = {1'b0, w_alu_x} + ({(XLEN+1){w_div}} ^ {1'b0, r_opnd}) +
              {{XLEN{1'b0}}, w_div};
    // the bit shifted out of the top guarantees the trial subtract fits
    w_ge    = r_acc[W2-1] | ~w_alu[XLEN];
    if (w_div)
      w_acc_nxt = w_ge ? {w_alu[XLEN-1:0], r_acc[XLEN-2:0], 1'b1} : {r_acc[W2-2:0], 1'b0};
    else
      w_acc_nxt = r_acc[0] ? {w_alu, r_acc[XLEN-1:1]} : {1'b0, r_acc[W2-1:1]};

    w_prod = cneg2(w_acc_nxt, r_sign_a ^ r_sign_b);
    w_quo  = cneg(w_acc_nxt[XLEN-1:0], r_sign_a ^ r_sign_b);
    w_rem  = cneg(w_acc_nxt[W2-1:XLEN], r_sign_a);

    case (r_f3)
      F3_MUL:                       w_result = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_result = w_prod[W2-1:XLEN];
      F3_DIV, F3_DIVU:              w_result = w_quo;
      default:                      w_result = w_rem;
    endcase
  end

  // datapath registers: only meaningful after an accepted start
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_f3     <= w_f3;
      r_sign_a <= w_a_signed & bus.op_a[XLEN-1];
      r_sign_b <= w_b_signed & bus.op_b[XLEN-1];
      r_rd_lat <= bus.rd_in;
      // multiply: acc low = multiplier, opnd = multiplicand
      // divide:   acc low = dividend,   opnd = divisor
      r_opnd   <= w_is_div ? w_mag_b : w_mag_a;
      r_acc    <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
    end else if (r_state == S_CALC) begin
      r_acc    <= w_acc_nxt;
    end
  end

  // control FSM with registered write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_wen   <= 1'b0;
      r_rd    <= '0;
      r_rdv   <= '0;
    end else begin
      r_done <= 1'b0;
      r_wen  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt <= '0;
            if (w_special) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_wen   <= (bus.rd_in != '0);
              r_rd    <= bus.rd_in;
              r_rdv   <= w_special_res;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
          end else if (r_cnt == 5'(STEPS - 1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_wen   <= (r_rd_lat != '0);
            r_rd    <= r_rd_lat;
            r_rdv   <= w_result;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready = (r_state == S_IDLE);
  assign bus.done  = r_done;
  assign bus.w_en  = r_wen;
  assign bus.rd    = r_rd;
  assign bus.rdv   = r_rdv;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Scoreboard bench for muldiv_unit: the driver pushes the expected write-back
// (index, value, enable, completion cycle) from an arithmetic reference model;
// a monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_if bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] rdv;
    logic        wen;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [4:0]  last_rd  = '0;
  logic [31:0] last_rdv = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference results straight from the RV32M definitions
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub, q;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb; return q[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        q = ua / ub; return q[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa % sb; return q[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        q = ua % ub; return q[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    if (f < 3'd4) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return (f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // called at a falling edge; returns at the falling edge after acceptance
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit expect_done);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout actual ready=0 required ready=1 within 200 cycles");
      return;
    end
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.rd_in  = rd;
    if (expect_done) begin
      e.rd  = rd;
      e.rdv = ref_op(f, a, b);
      e.wen = (rd != 5'd0);
      e.due = cyc + 1 + (is_special(f, a, b) ? 0 : 32);
      sb_q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_accept", bus.ready, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout actual pending=%0d required pending=0", sb_q.size());
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.done === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done actual done=1 rd=%0d rdv=0x%0h required no completion (cycle %0d)",
                   bus.rd, bus.rdv, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("wb_rd",    bus.rd,   e.rd);
          chk("wb_rdv",   bus.rdv,  e.rdv);
          chk("wb_wen",   bus.w_en, e.wen);
          chk("wb_cycle", cyc,      e.due);
          last_rd  = e.rd;
          last_rdv = e.rdv;
        end
        @(negedge clk);
        chk("ready_after_done", bus.ready, 1'b1);
        chk("done_one_cycle",   bus.done,  1'b0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = 3'd0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.rd_in  = '0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ready", bus.ready, 1'b1);
    chk("reset_done",  bus.done,  1'b0);
    chk("reset_wen",   bus.w_en,  1'b0);
    chk("reset_rd",    bus.rd,    5'd0);
    chk("reset_rdv",   bus.rdv,   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1);
    drain();
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1);
    issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2,   5'd6,  1);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2,   5'd7,  1);
    issue(3'd5, 32'd100,       32'd7,   5'd8,  1);
    issue(3'd7, 32'd100,       32'd7,   5'd9,  1);
    issue(3'd4, 32'd5,         32'd0,   5'd10, 1);
    issue(3'd7, 32'd5,         32'd0,   5'd11, 1);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1);
    drain();

    // flush mid-calculation, with an ignored start while busy
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd14, 0);
    repeat (5) @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'd4;
    bus.op_a   = 32'd100;
    bus.op_b   = 32'd3;
    bus.rd_in  = 5'd15;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_ready",   bus.ready, 1'b1);
    chk("flush_done",    bus.done,  1'b0);
    chk("flush_wen",     bus.w_en,  1'b0);
    chk("flush_rd_hold", bus.rd,    last_rd);
    chk("flush_rdv_hold", bus.rdv,  last_rdv);
    issue(3'd0, 32'd3, 32'd4, 5'd16, 1);
    drain();

    issue(3'd0, 32'd2, 32'd2, 5'd0, 1);
    drain();

    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)), 1);
    end
    drain();

    // asynchronous reset in the middle of a calculation
    issue(3'd5, $urandom, 32'd3, 5'd17, 0);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_ready", bus.ready, 1'b1);
    chk("areset_done",  bus.done,  1'b0);
    chk("areset_wen",   bus.w_en,  1'b0);
    chk("areset_rd",    bus.rd,    5'd0);
    chk("areset_rdv",   bus.rdv,   32'd0);
    last_rd  = '0;
    last_rdv = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(3'd7, 32'd100, 32'd7, 5'd18, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
